// File: rtl/permute_scatter_unit_pkg.sv
// Shared defaults for the lane scatter permutation block.
package permute_scatter_unit_pkg;

    localparam int unsigned DefaultLanes   = 4;
    localparam int unsigned DefaultWidth   = 8;
    localparam int unsigned DefaultSelWidth = 2;

endpackage

// File: rtl/permute_dest_decode.sv
// Decodes one lane's destination index into an N-bit one-hot hit vector.
module permute_dest_decode #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    hit,
    output logic            out_of_range
);

    // Zero-extend so the compare is correct for any SELW up to 32.
    logic [31:0] sel_ext;
    assign sel_ext = 32'(sel);

    always_comb begin
        hit = '0;
        for (int j = 0; j < int'(N); j++) begin
            hit[j] = (sel_ext == 32'(j));
        end
    end

    assign out_of_range = (sel_ext >= 32'(N));

endmodule

// File: rtl/permute_scatter_unit.sv
// Registered N-lane scatter: each input lane is written to the output lane named by its sel.
module permute_scatter_unit
    import permute_scatter_unit_pkg::*;
#(
    parameter int unsigned N    = DefaultLanes,
    parameter int unsigned W    = DefaultWidth,
    parameter int unsigned SELW = DefaultSelWidth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [N*W-1:0]    in_bus,
    input  logic [N*SELW-1:0] sel_in_bus,
    output logic              out_valid,
    output logic [N*W-1:0]    out_bus,
    output logic [N-1:0]      out_mask,
    output logic              conflict
);

    function automatic logic [W-1:0] data_lane(input logic [N*W-1:0] bus, input int unsigned idx);
        return bus[idx*W +: W];
    endfunction

    function automatic logic [SELW-1:0] sel_lane(input logic [N*SELW-1:0] bus,
                                                 input int unsigned idx);
        return bus[idx*SELW +: SELW];
    endfunction

    logic [N-1:0] hit [N];
    logic [N-1:0] oor;

    for (genvar i = 0; i < int'(N); i++) begin : g_decode
        permute_dest_decode #(
            .N    (N),
            .SELW (SELW)
        ) u_decode (
            .sel          (sel_lane(sel_in_bus, i)),
            .hit          (hit[i]),
            .out_of_range (oor[i])
        );
    end

    logic [N*W-1:0] out_next;
    logic [N-1:0]   mask_next;
    logic           multi_hit;
    logic           conflict_next;

    // Ascending lane scan: later (higher-index) hits overwrite earlier ones.
    always_comb begin
        out_next  = '0;
        mask_next = '0;
        multi_hit = 1'b0;
        for (int j = 0; j < int'(N); j++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (hit[i][j]) begin
                    if (mask_next[j]) begin
                        multi_hit = 1'b1;
                    end
                    mask_next[j]       = 1'b1;
                    out_next[j*W +: W] = data_lane(in_bus, i);
                end
            end
        end
        conflict_next = multi_hit | (|oor);
    end

    logic           out_valid_q;
    logic [N*W-1:0] out_bus_q;
    logic [N-1:0]   out_mask_q;
    logic           conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_bus_q   <= '0;
            out_mask_q  <= '0;
            conflict_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_bus_q  <= out_next;
                out_mask_q <= mask_next;
                conflict_q <= conflict_next;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bus   = out_bus_q;
    assign out_mask  = out_mask_q;
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_permute_scatter_unit.sv
// Directed bench for permute_scatter_unit: N=4 table vectors, streaming, reset, N=3 range.
module tb_permute_scatter_unit;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic [31:0] in_bus;
    logic [7:0]  sel_in_bus;
    logic        out_valid;
    logic [31:0] out_bus;
    logic [3:0]  out_mask;
    logic        conflict;

    logic        in_valid3;
    logic [23:0] in_bus3;
    logic [5:0]  sel_in_bus3;
    logic        out_valid3;
    logic [23:0] out_bus3;
    logic [2:0]  out_mask3;
    logic        conflict3;

    int errors;
    int checks;

    permute_scatter_unit #(
        .N    (4),
        .W    (8),
        .SELW (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bus     (in_bus),
        .sel_in_bus (sel_in_bus),
        .out_valid  (out_valid),
        .out_bus    (out_bus),
        .out_mask   (out_mask),
        .conflict   (conflict)
    );

    permute_scatter_unit #(
        .N    (3),
        .W    (8),
        .SELW (2)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid3),
        .in_bus     (in_bus3),
        .sel_in_bus (sel_in_bus3),
        .out_valid  (out_valid3),
        .out_bus    (out_bus3),
        .out_mask   (out_mask3),
        .conflict   (conflict3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] din;
        logic [7:0]  sel;
        logic [31:0] exp_bus;
        logic [3:0]  exp_mask;
        logic        exp_conf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic check_out4(input string name, input logic v, input logic [31:0] b,
                              input logic [3:0] m, input logic c);
        check({name, ".valid"}, 32'(out_valid), 32'(v));
        check({name, ".bus"}, out_bus, b);
        check({name, ".mask"}, 32'(out_mask), 32'(m));
        check({name, ".conflict"}, 32'(conflict), 32'(c));
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bus      = '0;
        sel_in_bus  = '0;
        in_valid3   = 1'b0;
        in_bus3     = '0;
        sel_in_bus3 = '0;

        // sel packed as {lane3, lane2, lane1, lane0}
        vecs[0] = '{"basic",    32'h40302010, 8'h87, 32'h10402030, 4'b1111, 1'b0};
        vecs[1] = '{"identity", 32'hDDCCBBAA, 8'hE4, 32'hDDCCBBAA, 4'b1111, 1'b0};
        vecs[2] = '{"collide",  32'h44332211, 8'h05, 32'h00002244, 4'b0011, 1'b1};
        vecs[3] = '{"all_to_2", 32'h04030201, 8'hAA, 32'h00040000, 4'b0100, 1'b1};
        vecs[4] = '{"reverse",  32'h44332211, 8'h1B, 32'h11223344, 4'b1111, 1'b0};
        vecs[5] = '{"rotate",   32'hA3A2A1A0, 8'h39, 32'hA2A1A0A3, 4'b1111, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_out4("reset", 1'b0, 32'h0, 4'h0, 1'b0);
        check("reset3.valid", 32'(out_valid3), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, one per cycle with an idle cycle between.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_bus     = vecs[k].din;
            sel_in_bus = vecs[k].sel;
            @(posedge clk);
            #1;
            check_out4(vecs[k].name, 1'b1, vecs[k].exp_bus, vecs[k].exp_mask, vecs[k].exp_conf);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check({vecs[k].name, ".idle_valid"}, 32'(out_valid), 32'h0);
        end

        // Streaming: three back-to-back vectors then idle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_bus     = vecs[k + 2].din;
            sel_in_bus = vecs[k + 2].sel;
            @(posedge clk);
            #1;
            check_out4("stream", 1'b1, vecs[k + 2].exp_bus, vecs[k + 2].exp_mask,
                       vecs[k + 2].exp_conf);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream.end_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-cycle while output is valid.
        @(negedge clk);
        in_valid   = 1'b1;
        in_bus     = vecs[0].din;
        sel_in_bus = vecs[0].sel;
        @(posedge clk);
        #1;
        check("pre_reset.valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out4("async_reset", 1'b0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid   = 1'b1;
        in_bus     = vecs[1].din;
        sel_in_bus = vecs[1].sel;
        @(posedge clk);
        #1;
        check_out4("first_after_reset", 1'b1, vecs[1].exp_bus, vecs[1].exp_mask,
                   vecs[1].exp_conf);
        @(negedge clk);
        in_valid = 1'b0;

        // N=3: lane0 sel=3 is dropped; lane1->0, lane2->1.
        @(negedge clk);
        in_valid3   = 1'b1;
        in_bus3     = 24'hCCBBAA;
        sel_in_bus3 = 6'h13;
        @(posedge clk);
        #1;
        check("oor.valid", 32'(out_valid3), 32'h1);
        check("oor.bus", 32'(out_bus3), 32'h00CCBB);
        check("oor.mask", 32'(out_mask3), 32'h3);
        check("oor.conflict", 32'(conflict3), 32'h1);

        @(negedge clk);
        in_bus3     = 24'h332211;
        sel_in_bus3 = 6'h09;
        @(posedge clk);
        #1;
        check("n3_perm.bus", 32'(out_bus3), 32'h221133);
        check("n3_perm.mask", 32'(out_mask3), 32'h7);
        check("n3_perm.conflict", 32'(conflict3), 32'h0);
        @(negedge clk);
        in_valid3 = 1'b0;
        @(posedge clk);
        #1;
        check("n3.idle_valid", 32'(out_valid3), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/permute_scatter_unit.md
# permute_scatter_unit

Registered N-lane scatter permutation for the multi-lane datapath. Each input lane i carries a W-bit word and a SELW-bit destination index; the word is written to output lane sel[i]. The block sits between lane-parallel processing stages wherever data must be re-ordered by a per-lane destination map. Output is registered with one cycle of latency, and collisions are flagged.

## Interface
- N, default 4: number of lanes; requires N ≥ 2 and N ≤ 2^SELW.
- W, default 8: data width per lane.
- SELW, default 2: destination index width per lane.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input vector valid this cycle.
- in_bus  in  N*W  lane i = in_bus[i*W +: W].
- sel_in_bus  in  N*SELW  destination of lane i = sel_in_bus[i*SELW +: SELW].
- out_valid  out  1  out_bus/out_mask/conflict valid.
- out_bus  out  N*W  lane j = out_bus[j*W +: W].
- out_mask  out  N  bit j set when some input lane targeted output j.
- conflict  out  1  two or more input lanes targeted the same output, or any sel ≥ N.

## Operation
- Combinational core, for each output j:
  - hit[i][j] = (sel[i] == j);
  - out_next[j] = in[i] of the highest-index i with hit[i][j] set, else 0;
  - mask_next[j] = OR over i of hit[i][j].
- conflict_next = (any output with two or more hits) OR (any sel[i] ≥ N). A lane with sel ≥ N is dropped and writes no output.
- Pure function of the current inputs; no state beyond the output registers.
- When in_valid = 1 at a clock edge, register out_bus ← out_next, out_mask ← mask_next, conflict ← conflict_next, out_valid ← 1.
- When in_valid = 0, set out_valid ← 0. out_bus, out_mask and conflict hold their previous values and are don't-care to consumers.
- No backpressure. A new vector is accepted every cycle.

## Timing
- Latency is exactly 1 cycle: the vector sampled at edge k appears at outputs after edge k.
- Throughput is 1 vector per cycle. Back-to-back valids produce back-to-back out_valid.
- Reset (asynchronous assert, synchronous release with the clock): out_valid = 0, out_bus = 0, out_mask = 0, conflict = 0.
- Reset asserted mid-stream clears all outputs immediately. The vector in flight is discarded.
- First in_valid after reset release produces out_valid on the following edge.

## Structure
- No shared package is required. The lane slicing helpers are local functions.
- One sub-module is natural: permute_dest_decode (SELW → N one-hot with an out-of-range flag), instantiated once per input lane.
- The selection per output is a priority OR-reduction over the N decoded hits. The top level generates the N output muxes and the output registers.

## Test plan
- Basic scatter (N=4, W=8):
  - in_bus = {40,30,20,10} hex, sel = {2,0,1,3}, in_valid = 1.
  - Next cycle: out_bus = {10,40,20,30} hex, out_mask = 1111, conflict = 0, out_valid = 1.
- Identity: sel = {3,2,1,0}, in_bus = {DD,CC,BB,AA} -> out_bus unchanged, mask = 1111, conflict = 0.
- Collision: sel = {0,0,1,1}, in_bus = {44,33,22,11}:
  - out lane0 = 44, out lane1 = 22, lanes 2 and 3 = 00;
  - mask = 0011, conflict = 1.
- Streaming: three consecutive valid vectors, then in_valid = 0.
  - out_valid is high for exactly three cycles, each result one cycle after its input.
  - Then out_valid = 0.
- Reset: assert rst_n = 0 between clock edges while out_valid = 1.
  - Outputs are immediately 0.
  - After release with in_valid = 0, out_valid stays 0.
- Out-of-range (N=3, SELW=2): lane with sel = 3 is dropped, conflict = 1, and its word appears in no output lane.
